countdown_timer: RTL and testbench
==================================

# countdown_timer

Programmable down-counting timer. It is the consuming counterpart to the free-running 4-bit up counter used elsewhere in the design. A producer hands it a start value over a valid/ready load handshake. It counts down at a prescaled rate and emits a one-cycle `expired` pulse on reaching terminal count. It supports one-shot and auto-reload modes, with pause and abort controls for control-path sequencing.

## Interface
Parameters:
- `WIDTH`, default 4 — width of the count and load value.
- `PRESCALE_W`, default 4 — width of the prescale divisor field.

Ports:
- `clk`  in  1  — clock; all state updates on the rising edge.
- `rst`  in  1  — reset; asynchronous, active-high.
- `load_valid`  in  1  — producer offers a new start value.
- `load_ready`  out  1  — timer can accept a load. High exactly when the FSM is in IDLE.
- `load_value`  in  WIDTH  — start count N.
- `prescale`  in  PRESCALE_W  — divisor P. The count decrements once every P+1 clocks.
- `auto_reload`  in  1  — 1 selects periodic mode, 0 selects one-shot. Sampled at load acceptance.
- `pause`  in  1  — level; freezes both the prescaler and the count while high.
- `abort`  in  1  — level; cancels a running countdown.
- `count`  out  WIDTH  — current remaining count.
- `busy`  out  1  — FSM is in RUN.
- `expired`  out  1  — registered single-cycle terminal-count pulse.

## Operation
- **States:** IDLE and RUN.
- **Internal registers:**
  - `reload_q` (WIDTH)
  - `presc_q` (PRESCALE_W)
  - `presc_cnt` (PRESCALE_W)
  - `mode_q`
- **Reset values:**
  - state = IDLE, so `busy` = 0 and `load_ready` = 1.
  - `count`, `expired`, `reload_q`, `presc_q`, `presc_cnt`, `mode_q` all 0.
- **Load acceptance:** occurs on an edge where `load_valid` && `load_ready`. On that edge:
  - `count` and `reload_q` take `load_value`.
  - `presc_q` takes `prescale`.
  - `mode_q` takes `auto_reload`.
  - `presc_cnt` clears to 0.
  - If N ≠ 0, state goes to RUN. If N = 0, state stays IDLE and `expired` = 1 for the following cycle.
- **Load ignored in RUN:** `load_valid` has no effect while in RUN because `load_ready` = 0. `abort` in IDLE is ignored; a load is still accepted.
- **Tick:** tick = RUN && !`pause` && `presc_cnt` == `presc_q`.
  - In RUN with !`pause`: `presc_cnt` increments, and clears to 0 on a tick.
  - On a tick with `count` > 1: `count` decrements by 1.
  - On a tick with `count` == 1:
    - `expired` = 1 for the next cycle.
    - One-shot: `count` goes to 0 and state returns to IDLE.
    - Auto-reload: `count` takes `reload_q` and state stays RUN.
  - In auto-reload mode `count` never shows 0 while running.
- **Pause:** while `pause` = 1 in RUN, `presc_cnt`, `count` and state all hold.
- **Priority in RUN:** `abort` > `pause` > tick.
  - On `abort`: `count` goes to 0, `presc_cnt` goes to 0, state returns to IDLE, and no `expired` pulse is produced.
  - If `abort` coincides with a terminal tick, `abort` wins and `expired` stays 0.
- **Expired pulse:** `expired` is 0 on every cycle except the pulse cycles defined above.
- **Arithmetic:**
  - `count` is unsigned and never wraps below 0.
  - Maximum N = 2^WIDTH − 1. With WIDTH = 4, N = 15 is valid.
  - `presc_cnt` compares against `presc_q` (a latched value), so changing `prescale` mid-run has no effect.

## Timing
- Load accepted at edge E0 with N ≥ 1 and P = 0: `count` is N after E0 and 0 after E(N). `expired` is high during the cycle following E(N), and `busy` falls on that same edge E(N).
- Total latency, load edge to the `expired` pulse: N·(P+1) clocks, plus any cycles with `pause` high.
- Auto-reload period: `expired` pulses every N·(P+1) clocks, and a new load is not possible without `abort`.
- `load_ready` rises in the same cycle `expired` is high (one-shot), so a back-to-back reload is accepted on the next edge.
- Asserting `rst` at any time forces all outputs to their reset values immediately, with no clock required. This includes clearing a pending `expired`.

## Test plan
- **Reset:** load N = 9, P = 0; assert `rst` asynchronously 3 cycles later.
  - Required: `count` = 0, `busy` = 0, `load_ready` = 1, `expired` = 0 with no clock edge.
  - After release, no pulse ever appears.
- **One-shot:** load N = 5, P = 0.
  - Required: `count` goes 5, 4, 3, 2, 1, 0 on consecutive cycles; `expired` is high for exactly one cycle, aligned with `count` = 0; `busy` = 0 and `load_ready` = 1 on that cycle.
- **Prescale:** load N = 3, P = 2.
  - Required: each count value is held for 3 cycles; `expired` asserts 9 clocks after the load edge.
- **Auto-reload and abort:** N = 4, P = 0, `auto_reload` = 1.
  - Required: `count` goes 4, 3, 2, 1, 4, 3, …; `expired` pulses every 4 cycles.
  - Assert `abort` when `count` = 1: `count` = 0, state IDLE, no pulse.
- **Pause:** N = 6, P = 1; hold `pause` for 5 cycles while `count` = 4.
  - Required: `count` and `presc_cnt` are frozen; `expired` arrives at 12 + 5 = 17 clocks after load.
- **Boundaries:**
  - Load N = 0: `expired` pulses the next cycle and `busy` stays 0.
  - Load N = 15: `expired` arrives after exactly 15 clocks.
  - `load_valid` with N = 7 asserted mid-run: ignored; `count` is unaffected.

Source files
------------

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Programmable down-counting timer. A producer hands over a start value on a
// valid/ready load handshake; the timer then counts down once every
// prescale+1 clocks and emits a registered one-cycle expired pulse when the
// count reaches terminal count. Supports one-shot and auto-reload modes,
// plus pause and abort controls.
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   rst         - asynchronous active-high reset
//   load_valid  - producer offers a new start value
//   load_ready  - high exactly while the FSM is in IDLE
//   load_value  - start count N
//   prescale    - divisor P, the count decrements every P+1 clocks
//   auto_reload - 1 = periodic, 0 = one-shot (sampled at load acceptance)
//   pause       - level, freezes prescaler and count while high
//   abort       - level, cancels a running countdown without a pulse
//   count       - current remaining count
//   busy        - FSM is in RUN
//   expired     - registered single-cycle terminal-count pulse
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WIDTH-1:0]      load_value,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  auto_reload,
    input  logic                  pause,
    input  logic                  abort,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  expired
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        count_q, count_d;
    logic [WIDTH-1:0]        reload_q, reload_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic [PRESCALE_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic                    mode_q, mode_d;
    logic                    expired_q, expired_d;
    logic                    tick;

    // The prescaler compares against the divisor latched at load time, so a
    // change on the prescale input during a run is deliberately invisible.
    assign tick = (state_q == RUN) && !pause && (presc_cnt_q == presc_q);

    // All state, including the pending expired pulse, is cleared by the
    // asynchronous reset so outputs drop without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            reload_q    <= '0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            mode_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            mode_q      <= mode_d;
            expired_q   <= expired_d;
        end
    end

    // Next-state logic. In RUN the priority is abort, then pause, then the
    // prescaler/tick path. expired defaults low so it only ever lasts one
    // cycle.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        mode_d      = mode_q;
        expired_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // abort is ignored here; a load is accepted regardless.
                if (load_valid) begin
                    count_d     = load_value;
                    reload_d    = load_value;
                    presc_d     = prescale;
                    mode_d      = auto_reload;
                    presc_cnt_d = '0;
                    // A zero start value is already at terminal count.
                    if (load_value != '0) begin
                        state_d = RUN;
                    end else begin
                        expired_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    count_d     = '0;
                    presc_cnt_d = '0;
                    state_d     = IDLE;
                end else if (!pause) begin
                    if (tick) begin
                        presc_cnt_d = '0;
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            // Terminal count: auto-reload jumps straight back
                            // to the start value so 0 is never shown.
                            expired_d = 1'b1;
                            if (mode_q) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        presc_cnt_d = presc_cnt_q + PRESCALE_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign count      = count_q;
    assign expired    = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//
// Self-checking bench for countdown_timer. A table of per-cycle vectors
// covers one-shot, auto-reload, abort, mid-run loads and zero loads; hand
// sequences cover prescale, pause, the maximum start value and async reset.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

    logic       clk;
    logic       rst;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_value;
    logic [3:0] prescale;
    logic       auto_reload;
    logic       pause;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       expired;

    int checks;
    int failures;

    typedef struct {
        logic       lv;
        logic [3:0] val;
        logic [3:0] ps;
        logic       ar;
        logic       pa;
        logic       ab;
        logic [3:0] expCount;
        logic       expBusy;
        logic       expReady;
        logic       expExpired;
    } vec_t;

    vec_t vecs[$];

    countdown_timer #(.WIDTH(4), .PRESCALE_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .prescale    (prescale),
        .auto_reload (auto_reload),
        .pause       (pause),
        .abort       (abort),
        .count       (count),
        .busy        (busy),
        .expired     (expired)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one value and reports a mismatch on a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, lets a rising edge pass, and returns 1 ns
    // after that edge so outputs are sampled away from the clock.
    task automatic applyStimulus(input logic lv, input logic [3:0] val,
                                 input logic [3:0] ps, input logic ar,
                                 input logic pa, input logic ab);
        load_valid  = lv;
        load_value  = val;
        prescale    = ps;
        auto_reload = ar;
        pause       = pa;
        abort       = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input int lv, input int val, input int ar,
                          input int ab, input int c, input int b,
                          input int r, input int e);
        vec_t v;
        v.lv         = 1'(lv);
        v.val        = 4'(val);
        v.ps         = 4'd0;
        v.ar         = 1'(ar);
        v.pa         = 1'b0;
        v.ab         = 1'(ab);
        v.expCount   = 4'(c);
        v.expBusy    = 1'(b);
        v.expReady   = 1'(r);
        v.expExpired = 1'(e);
        vecs.push_back(v);
    endtask

    // Idles until expired is seen, counting edges from startN, bounded.
    task automatic waitExpired(input int startN, input int maxN,
                               output int n, output bit seen);
        n    = startN;
        seen = 1'b0;
        while (!seen && n < maxN) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            n++;
            if (expired === 1'b1) seen = 1'b1;
        end
    endtask

    initial begin
        int  n;
        bit  seen;
        int  pulses;
        int  busyCycles;
        logic [3:0] expC;

        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        load_valid  = 1'b0;
        load_value  = 4'd0;
        prescale    = 4'd0;
        auto_reload = 1'b0;
        pause       = 1'b0;
        abort       = 1'b0;

        // Reset state.
        #12;
        checkOutput("reset_count", 32'(count), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_ready", 32'(load_ready), 1);
        checkOutput("reset_expired", 32'(expired), 0);
        @(negedge clk);
        rst = 1'b0;

        // lv, val, ar, ab -> count, busy, ready, expired
        // One-shot N=5, P=0.
        addVec(1, 5, 0, 0, 5, 1, 0, 0);
        addVec(0, 0, 0, 0, 4, 1, 0, 0);
        addVec(0, 0, 0, 0, 3, 1, 0, 0);
        addVec(0, 0, 0, 0, 2, 1, 0, 0);
        addVec(0, 0, 0, 0, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 1, 1);
        addVec(0, 0, 0, 0, 0, 0, 1, 0);
        // Auto-reload N=4 with ignored mid-run loads and abort at count 1.
        addVec(1, 4, 1, 0, 4, 1, 0, 0);
        addVec(0, 0, 0, 0, 3, 1, 0, 0);
        addVec(0, 0, 0, 0, 2, 1, 0, 0);
        addVec(0, 0, 0, 0, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 4, 1, 0, 1);
        addVec(1, 7, 0, 0, 3, 1, 0, 0);
        addVec(1, 7, 0, 0, 2, 1, 0, 0);
        addVec(0, 0, 0, 0, 1, 1, 0, 0);
        addVec(0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 0, 0, 1, 0);
        // abort in IDLE does not block a load.
        addVec(1, 2, 0, 1, 2, 1, 0, 0);
        addVec(0, 0, 0, 0, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 1, 1);
        // Back-to-back load during the expired cycle.
        addVec(1, 1, 0, 0, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 1, 1);
        // Zero load pulses next cycle, never busy.
        addVec(1, 0, 0, 0, 0, 0, 1, 1);
        addVec(0, 0, 0, 0, 0, 0, 1, 0);
        // Abort on the terminal tick suppresses the pulse.
        addVec(1, 1, 0, 0, 1, 1, 0, 0);
        addVec(0, 0, 0, 1, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].lv, vecs[i].val, vecs[i].ps, vecs[i].ar,
                          vecs[i].pa, vecs[i].ab);
            checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d_ready", i), 32'(load_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d_expired", i), 32'(expired), 32'(vecs[i].expExpired));
        end

        // Prescale N=3, P=2; prescale input changed to 0 after the load.
        applyStimulus(1'b1, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0);
        checkOutput("presc_load_count", 32'(count), 3);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            expC = (k < 9) ? 4'(3 - k / 3) : 4'd0;
            checkOutput($sformatf("presc_k%0d_count", k), 32'(count), 32'(expC));
            checkOutput($sformatf("presc_k%0d_expired", k), 32'(expired), (k == 9) ? 1 : 0);
        end

        // Pause N=6, P=1: freeze for 5 cycles while count is 4.
        applyStimulus(1'b1, 4'd6, 4'd1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("pause_pre_count", 32'(count), 4);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("pause_hold%0d_count", k), 32'(count), 4);
        end
        // Prescaler must also have held: 4 remains for two more edges.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("pause_resume_count", 32'(count), 4);
        waitExpired(10, 40, n, seen);
        checkOutput("pause_seen", 32'(seen), 1);
        checkOutput("pause_latency", 32'(n), 17);

        // Maximum start value N=15, P=0.
        applyStimulus(1'b1, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("max_load_count", 32'(count), 15);
        waitExpired(0, 40, n, seen);
        checkOutput("max_seen", 32'(seen), 1);
        checkOutput("max_latency", 32'(n), 15);
        checkOutput("max_end_count", 32'(count), 0);

        // Asynchronous reset mid-run: load 9, three more edges, then reset
        // between clock edges.
        applyStimulus(1'b1, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("arst_pre_count", 32'(count), 6);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_count", 32'(count), 0);
        checkOutput("arst_busy", 32'(busy), 0);
        checkOutput("arst_ready", 32'(load_ready), 1);
        checkOutput("arst_expired", 32'(expired), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses     = 0;
        busyCycles = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
            if (expired !== 1'b0) pulses++;
            if (busy !== 1'b0) busyCycles++;
        end
        checkOutput("arst_after_pulses", 32'(pulses), 0);
        checkOutput("arst_after_busy", 32'(busyCycles), 0);

        // Reset clears a pending expired pulse without a clock edge.
        applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("arst_pend_pre", 32'(expired), 1);
        load_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_pend_expired", 32'(expired), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("arst_pend_after", 32'(expired), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
